timer_alert_flasher: RTL and testbench
======================================

Name: timer_alert_flasher

Overview:
- Parametrised successor to the two-mode timer flasher.
- Drives one alert LED from the elapsed-time count. The LED blinks slowly when the target time is near and fast when it is close or overrun.
- When the timer stops, the LED gives a fixed-length completion burst.
- Sits between the timer datapath (Count, Stopped, ModeSel) and the LED output. It runs on the system clock and uses a TickIn strobe, not a derived clock.

Parameters:
- CNT_W, 8: width of Count and Limit (binary).
- LIMIT_A, 99: mode A target count (must fit CNT_W).
- WARN_WIN, 9: remaining <= WARN_WIN selects slow blink.
- URGENT_WIN, 2: remaining <= URGENT_WIN selects fast blink (URGENT_WIN < WARN_WIN).
- SLOW_HALF, 5: TickIn strobes per LED half-period in WARN.
- FAST_HALF, 1: TickIn strobes per LED half-period in URGENT and BURST.
- BURST_N, 3: number of on/off pairs in the completion burst.

Ports:
- CLK  input  1  system clock; all state on rising edge.
- Reset  input  1  synchronous, active-high reset.
- TickIn  input  1  one-cycle blink time-base strobe.
- Stopped  input  1  timer finished/halted.
- ModeSel  input  1  0 = mode A (target LIMIT_A), 1 = mode B (target Limit).
- Count  input  CNT_W  elapsed count.
- Limit  input  CNT_W  mode B target.
- FlashingLED  output  1  LED drive, registered.
- AlertState  output  3  current FSM state, registered.

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - State IDLE, FlashingLED 0, phase counter 0, burst counter 0, Stopped history 0.
- Target and remaining:
  - target = ModeSel ? Limit : LIMIT_A.
  - remaining = target - Count, saturating at 0 when Count >= target.
  - Computed at CNT_W+1 bits internally, so there is no wrap-around.
- States (one-hot-free 3-bit encoding): IDLE=0, WARN=1, URGENT=2, BURST=3, OFF=4.
- Transitions, evaluated every CLK, with registered outputs (1-cycle latency from input change):
  - Stopped rising edge (Stopped=1 and previous Stopped=0) from any state -> BURST. This has priority over the window checks.
  - BURST -> OFF after 2*BURST_N LED toggles.
  - BURST or OFF with Stopped=0 -> IDLE.
  - IDLE, WARN, URGENT with Stopped=0:
    - remaining <= URGENT_WIN -> URGENT.
    - else remaining <= WARN_WIN -> WARN.
    - else -> IDLE.
  - Stopped=1 held without an edge (including out of reset) -> OFF, LED 0.
- Blink generator:
  - On entering WARN, URGENT or BURST: phase <= 0 and FlashingLED <= 1, on the same edge the state changes.
  - While in one of those states: on each TickIn, if phase == HALF-1 then phase <= 0 and FlashingLED toggles; otherwise phase++. HALF is SLOW_HALF in WARN and FAST_HALF otherwise.
  - TickIn on the entry cycle is ignored.
  - IDLE and OFF: FlashingLED 0, phase held at 0.
- Mid-operation changes:
  - A ModeSel or Limit change that moves the window re-evaluates next cycle. A state change restarts the phase.
  - Staying in the same state does not disturb the phase.
- Overrun: Count > target with Stopped=0 stays in URGENT indefinitely.
- Mode B Limit=0: remaining 0 -> URGENT immediately.
- Burst counter counts toggles only in BURST and clears on any other state.

Decomposition:
- Shared package flasher_pkg holds:
  - state encoding localparams;
  - AlertState width;
  - default window/half-period constants.
- One natural sub-module, flash_phase_gen:
  - phase counter and toggle register;
  - inputs: restart, enable, TickIn, half-period select;
  - outputs: LED, toggle pulse.
- The FSM and remaining-time arithmetic stay in the top level.

Test Plan (defaults):
- Reset with Stopped=0, Count=0: AlertState=0 and LED=0 from the first post-reset cycle. Assert Reset mid-WARN: IDLE, LED 0 the next cycle.
- Mode A, Count=90 (remaining 9): next cycle AlertState=1, LED=1; toggles after every 5th TickIn. Count=89 -> IDLE, LED 0.
- Mode A, Count=97 (remaining 2): URGENT, LED toggles every TickIn. Count=120 (overrun) stays URGENT.
- Mode B, Limit=20, Count=12 -> WARN. Switch ModeSel to 0 -> IDLE one cycle later. Back to 1 -> WARN with the phase restarted and LED=1.
- From URGENT, raise Stopped: BURST with LED=1, exactly 6 toggles (3 on/off pairs) over 6 TickIns, then AlertState=4, LED 0. Drop Stopped -> IDLE.
- Stopped held high out of reset: OFF, no burst. A TickIn arriving on the WARN entry cycle does not advance the phase.

Source files
------------

// File: rtl/flasher_pkg.sv
// rtl/flasher_pkg.sv - shared state encoding and default constants for the alert flasher
package flasher_pkg;

    localparam int ALERT_W = 3;

    typedef enum logic [ALERT_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_WARN   = 3'd1,
        ST_URGENT = 3'd2,
        ST_BURST  = 3'd3,
        ST_OFF    = 3'd4
    } alert_state_t;

    localparam int DEF_CNT_W      = 8;
    localparam int DEF_LIMIT_A    = 99;
    localparam int DEF_WARN_WIN   = 9;
    localparam int DEF_URGENT_WIN = 2;
    localparam int DEF_SLOW_HALF  = 5;
    localparam int DEF_FAST_HALF  = 1;
    localparam int DEF_BURST_N    = 3;

    // Bits needed to hold every value in 0..max_val.
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) w++;
        return w;
    endfunction

    function automatic logic is_blink_state(input alert_state_t s);
        return (s == ST_WARN) || (s == ST_URGENT) || (s == ST_BURST);
    endfunction

endpackage

// File: rtl/flash_phase_gen.sv
// rtl/flash_phase_gen.sv - TickIn-driven half-period counter and LED toggle register
module flash_phase_gen
    import flasher_pkg::*;
#(
    parameter int SLOW_HALF = DEF_SLOW_HALF,
    parameter int FAST_HALF = DEF_FAST_HALF
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_restart,
    input  logic i_clear,
    input  logic i_enable,
    input  logic i_tick,
    input  logic i_fast,
    output logic o_led,
    output logic o_toggle
);

    localparam int PH_W = cnt_width((SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF);

    logic [PH_W-1:0] r_phase;
    logic            r_led;
    logic [PH_W-1:0] w_half_m1;
    logic            w_wrap;

    assign w_half_m1 = i_fast ? PH_W'(FAST_HALF - 1) : PH_W'(SLOW_HALF - 1);
    assign w_wrap    = (r_phase == w_half_m1);
    assign o_toggle  = i_enable & i_tick & w_wrap;
    assign o_led     = r_led;

    // Restart wins over tick so a strobe on the entry cycle never advances the phase.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_phase <= '0;
            r_led   <= 1'b0;
        end else if (i_restart) begin
            r_phase <= '0;
            r_led   <= 1'b1;
        end else if (i_clear) begin
            r_phase <= '0;
            r_led   <= 1'b0;
        end else if (i_enable && i_tick) begin
            if (w_wrap) begin
                r_phase <= '0;
                r_led   <= ~r_led;
            end else begin
                r_phase <= r_phase + PH_W'(1);
            end
        end
    end

endmodule

// File: rtl/timer_alert_flasher.sv
// rtl/timer_alert_flasher.sv - alert LED FSM driven by remaining time and timer stop events
module timer_alert_flasher
    import flasher_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int LIMIT_A    = DEF_LIMIT_A,
    parameter int WARN_WIN   = DEF_WARN_WIN,
    parameter int URGENT_WIN = DEF_URGENT_WIN,
    parameter int SLOW_HALF  = DEF_SLOW_HALF,
    parameter int FAST_HALF  = DEF_FAST_HALF,
    parameter int BURST_N    = DEF_BURST_N
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               TickIn,
    input  logic               Stopped,
    input  logic               ModeSel,
    input  logic [CNT_W-1:0]   Count,
    input  logic [CNT_W-1:0]   Limit,
    output logic               FlashingLED,
    output logic [ALERT_W-1:0] AlertState
);

    localparam int              BC_W       = cnt_width(2 * BURST_N);
    localparam logic [BC_W-1:0] BC_LAST    = BC_W'(2 * BURST_N - 1);
    localparam logic [CNT_W:0]  WARN_LIM   = (CNT_W + 1)'(WARN_WIN);
    localparam logic [CNT_W:0]  URGENT_LIM = (CNT_W + 1)'(URGENT_WIN);

    alert_state_t    r_state;
    alert_state_t    w_next;
    logic            r_stopped_d;
    logic            r_after_rst;
    logic [BC_W-1:0] r_burst_cnt;

    logic [CNT_W-1:0] w_target;
    logic [CNT_W:0]   w_diff;
    logic [CNT_W:0]   w_remaining;
    logic             w_stop_edge;
    logic             w_toggle;
    logic             w_cur_blink;
    logic             w_next_blink;
    logic             w_restart;

    // Extra top bit makes Count > target show up as a borrow instead of wrapping.
    assign w_target    = ModeSel ? Limit : CNT_W'(LIMIT_A);
    assign w_diff      = {1'b0, w_target} - {1'b0, Count};
    assign w_remaining = w_diff[CNT_W] ? '0 : w_diff;

    // The first cycle after reset treats a high Stopped as held, not as a new edge.
    assign w_stop_edge = Stopped & ~r_stopped_d & ~r_after_rst;

    assign w_cur_blink  = is_blink_state(r_state);
    assign w_next_blink = is_blink_state(w_next);
    assign w_restart    = w_next_blink && (w_next != r_state);

    always_comb begin
        w_next = r_state;
        if (w_stop_edge) begin
            w_next = ST_BURST;
        end else begin
            case (r_state)
                ST_BURST: begin
                    if (!Stopped)
                        w_next = ST_IDLE;
                    else if (w_toggle && (r_burst_cnt == BC_LAST))
                        w_next = ST_OFF;
                end
                ST_OFF: begin
                    if (!Stopped)
                        w_next = ST_IDLE;
                end
                default: begin
                    if (Stopped)
                        w_next = ST_OFF;
                    else if (w_remaining <= URGENT_LIM)
                        w_next = ST_URGENT;
                    else if (w_remaining <= WARN_LIM)
                        w_next = ST_WARN;
                    else
                        w_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_stopped_d <= 1'b0;
            r_after_rst <= 1'b1;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_next;
            r_stopped_d <= Stopped;
            r_after_rst <= 1'b0;
            if ((r_state == ST_BURST) && (w_next == ST_BURST)) begin
                if (w_toggle)
                    r_burst_cnt <= r_burst_cnt + BC_W'(1);
            end else begin
                r_burst_cnt <= '0;
            end
        end
    end

    flash_phase_gen #(
        .SLOW_HALF (SLOW_HALF),
        .FAST_HALF (FAST_HALF)
    ) u_phase (
        .i_clk     (CLK),
        .i_reset   (Reset),
        .i_restart (w_restart),
        .i_clear   (~w_next_blink),
        .i_enable  (w_cur_blink),
        .i_tick    (TickIn),
        .i_fast    (r_state != ST_WARN),
        .o_led     (FlashingLED),
        .o_toggle  (w_toggle)
    );

    assign AlertState = r_state;

endmodule

// File: tb/tb_timer_alert_flasher.sv
// tb/tb_timer_alert_flasher.sv - scoreboard bench for timer_alert_flasher with default parameters
module tb_timer_alert_flasher;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       TickIn;
    logic       Stopped;
    logic       ModeSel;
    logic [7:0] Count;
    logic [7:0] Limit;
    logic       FlashingLED;
    logic [2:0] AlertState;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] q_exp_st[$];
    logic [2:0] q_act_st[$];
    logic       q_exp_led[$];
    logic       q_act_led[$];

    always #5 CLK = ~CLK;

    timer_alert_flasher dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .TickIn      (TickIn),
        .Stopped     (Stopped),
        .ModeSel     (ModeSel),
        .Count       (Count),
        .Limit       (Limit),
        .FlashingLED (FlashingLED),
        .AlertState  (AlertState)
    );

    // One clock of stimulus: expectation queued now, DUT result captured 1 ns after the edge.
    task automatic drive(input logic rst, input logic tick, input logic stop, input logic mode,
                         input logic [7:0] cnt, input logic [7:0] lim,
                         input logic [2:0] st, input logic led);
        Reset   = rst;
        TickIn  = tick;
        Stopped = stop;
        ModeSel = mode;
        Count   = cnt;
        Limit   = lim;
        q_exp_st.push_back(st);
        q_exp_led.push_back(led);
        @(posedge CLK);
        #1;
        q_act_st.push_back(AlertState);
        q_act_led.push_back(FlashingLED);
        TickIn = 1'b0;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; q_exp_st.size() > 0; i++) begin
            logic [2:0] es, as;
            logic el, al;
            es = q_exp_st.pop_front();  as = q_act_st.pop_front();
            el = q_exp_led.pop_front(); al = q_act_led.pop_front();
            n_checks++;
            if (as !== es) begin n_fail++; $display("FAIL reset[%0d] AlertState got %0d want %0d", i, as, es); end
            n_checks++;
            if (al !== el) begin n_fail++; $display("FAIL reset[%0d] FlashingLED got %0b want %0b", i, al, el); end
        end
    endtask

    task automatic test_warn();
        drive(0, 0, 0, 0, 90, 0, 1, 1);
        drive(0, 1, 0, 0, 90, 0, 1, 1);
        drive(0, 0, 0, 0, 90, 0, 1, 1);
        repeat (3) drive(0, 1, 0, 0, 90, 0, 1, 1);
        drive(0, 1, 0, 0, 90, 0, 1, 0);
        repeat (4) drive(0, 1, 0, 0, 90, 0, 1, 0);
        drive(0, 1, 0, 0, 90, 0, 1, 1);
        drive(1, 0, 0, 0, 90, 0, 0, 0);
        drive(0, 0, 0, 0, 90, 0, 1, 1);
        drive(0, 0, 0, 0, 89, 0, 0, 0);
        drive(0, 0, 0, 0, 91, 0, 1, 1);
        for (int i = 0; q_exp_st.size() > 0; i++) begin
            logic [2:0] es, as;
            logic el, al;
            es = q_exp_st.pop_front();  as = q_act_st.pop_front();
            el = q_exp_led.pop_front(); al = q_act_led.pop_front();
            n_checks++;
            if (as !== es) begin n_fail++; $display("FAIL warn[%0d] AlertState got %0d want %0d", i, as, es); end
            n_checks++;
            if (al !== el) begin n_fail++; $display("FAIL warn[%0d] FlashingLED got %0b want %0b", i, al, el); end
        end
    endtask

    task automatic test_urgent();
        drive(0, 0, 0, 0, 97, 0, 2, 1);
        drive(0, 1, 0, 0, 97, 0, 2, 0);
        drive(0, 1, 0, 0, 97, 0, 2, 1);
        drive(0, 0, 0, 0, 97, 0, 2, 1);
        drive(0, 1, 0, 0, 99, 0, 2, 0);
        drive(0, 1, 0, 0, 120, 0, 2, 1);
        drive(0, 0, 0, 0, 120, 0, 2, 1);
        drive(0, 0, 0, 0, 96, 0, 1, 1);
        drive(0, 0, 0, 0, 97, 0, 2, 1);
        for (int i = 0; q_exp_st.size() > 0; i++) begin
            logic [2:0] es, as;
            logic el, al;
            es = q_exp_st.pop_front();  as = q_act_st.pop_front();
            el = q_exp_led.pop_front(); al = q_act_led.pop_front();
            n_checks++;
            if (as !== es) begin n_fail++; $display("FAIL urgent[%0d] AlertState got %0d want %0d", i, as, es); end
            n_checks++;
            if (al !== el) begin n_fail++; $display("FAIL urgent[%0d] FlashingLED got %0b want %0b", i, al, el); end
        end
    endtask

    task automatic test_mode_b();
        drive(0, 0, 0, 1, 12, 20, 1, 1);
        repeat (2) drive(0, 1, 0, 1, 12, 20, 1, 1);
        drive(0, 0, 0, 0, 12, 20, 0, 0);
        drive(0, 0, 0, 1, 12, 20, 1, 1);
        repeat (4) drive(0, 1, 0, 1, 12, 20, 1, 1);
        drive(0, 1, 0, 1, 12, 20, 1, 0);
        drive(0, 0, 0, 1, 12, 14, 2, 1);
        drive(0, 0, 0, 1, 10, 20, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 2, 1);
        drive(0, 0, 0, 1, 11, 20, 1, 1);
        drive(0, 0, 0, 1, 18, 20, 2, 1);
        drive(0, 0, 0, 1, 17, 20, 1, 1);
        for (int i = 0; q_exp_st.size() > 0; i++) begin
            logic [2:0] es, as;
            logic el, al;
            es = q_exp_st.pop_front();  as = q_act_st.pop_front();
            el = q_exp_led.pop_front(); al = q_act_led.pop_front();
            n_checks++;
            if (as !== es) begin n_fail++; $display("FAIL mode_b[%0d] AlertState got %0d want %0d", i, as, es); end
            n_checks++;
            if (al !== el) begin n_fail++; $display("FAIL mode_b[%0d] FlashingLED got %0b want %0b", i, al, el); end
        end
    endtask

    task automatic test_burst();
        drive(0, 0, 0, 0, 97, 0, 2, 1);
        drive(0, 1, 0, 0, 97, 0, 2, 0);
        drive(0, 1, 1, 0, 97, 0, 3, 1);
        drive(0, 1, 1, 0, 97, 0, 3, 0);
        drive(0, 1, 1, 0, 97, 0, 3, 1);
        drive(0, 0, 1, 0, 97, 0, 3, 1);
        drive(0, 1, 1, 0, 97, 0, 3, 0);
        drive(0, 1, 1, 0, 97, 0, 3, 1);
        drive(0, 1, 1, 0, 97, 0, 3, 0);
        drive(0, 1, 1, 0, 97, 0, 4, 0);
        drive(0, 0, 1, 0, 97, 0, 4, 0);
        drive(0, 1, 1, 0, 97, 0, 4, 0);
        drive(0, 0, 0, 0, 97, 0, 0, 0);
        drive(0, 0, 0, 0, 97, 0, 2, 1);
        for (int i = 0; q_exp_st.size() > 0; i++) begin
            logic [2:0] es, as;
            logic el, al;
            es = q_exp_st.pop_front();  as = q_act_st.pop_front();
            el = q_exp_led.pop_front(); al = q_act_led.pop_front();
            n_checks++;
            if (as !== es) begin n_fail++; $display("FAIL burst[%0d] AlertState got %0d want %0d", i, as, es); end
            n_checks++;
            if (al !== el) begin n_fail++; $display("FAIL burst[%0d] FlashingLED got %0b want %0b", i, al, el); end
        end
    endtask

    task automatic test_stop_held();
        drive(1, 0, 1, 0, 90, 0, 0, 0);
        drive(0, 0, 1, 0, 90, 0, 4, 0);
        drive(0, 1, 1, 0, 90, 0, 4, 0);
        drive(0, 0, 0, 0, 90, 0, 0, 0);
        drive(0, 1, 0, 0, 90, 0, 1, 1);
        repeat (4) drive(0, 1, 0, 0, 90, 0, 1, 1);
        drive(0, 1, 0, 0, 90, 0, 1, 0);
        drive(0, 0, 1, 0, 90, 0, 3, 1);
        drive(0, 0, 0, 0, 90, 0, 0, 0);
        drive(0, 0, 0, 0, 90, 0, 1, 1);
        for (int i = 0; q_exp_st.size() > 0; i++) begin
            logic [2:0] es, as;
            logic el, al;
            es = q_exp_st.pop_front();  as = q_act_st.pop_front();
            el = q_exp_led.pop_front(); al = q_act_led.pop_front();
            n_checks++;
            if (as !== es) begin n_fail++; $display("FAIL stop_held[%0d] AlertState got %0d want %0d", i, as, es); end
            n_checks++;
            if (al !== el) begin n_fail++; $display("FAIL stop_held[%0d] FlashingLED got %0b want %0b", i, al, el); end
        end
    endtask

    initial begin
        Reset   = 1'b1;
        TickIn  = 1'b0;
        Stopped = 1'b0;
        ModeSel = 1'b0;
        Count   = '0;
        Limit   = '0;
        #1;
        test_reset();
        test_warn();
        test_urgent();
        test_mode_b();
        test_burst();
        test_stop_held();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
